regfile_param: RTL

Parametrised successor to the CPU's 32x32 register file. It provides:
- configurable data width and address width;
- two asynchronous read ports and two synchronous write ports, with port A winning on collisions;
- an optional hardwired-zero register 0;
- a hardware sweep-clear sequencer that zeroes the array one entry per cycle.

It sits in the CPU datapath between decode/writeback and the ALU operand muxes, and is usable wherever a multi-ported register array is needed.

---
 rtl/regfile_param_if.sv | 43 ++++
 rtl/regfile_param.sv | 125 ++++++++++++
 2 files changed

// File: rtl/regfile_param_if.sv
// ---------------------------------------------------------------------------
// regfile_param_if
// Bus bundle for the parametrised register file.
//   master : the datapath side. It drives the read/write addresses, the write
//            data and enables and clearStart. It observes the read data,
//            clearBusy and writeConflict.
//   slave  : the register file side.
// Clk and reset are not part of this bundle; they stay plain module ports.
// ---------------------------------------------------------------------------
interface regfile_param_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] readRegister1;
  logic [ADDR_W-1:0] readRegister2;
  logic [WIDTH-1:0]  readData1;
  logic [WIDTH-1:0]  readData2;
  logic [ADDR_W-1:0] writeRegister;
  logic [WIDTH-1:0]  writeData;
  logic              regWrite;
  logic [ADDR_W-1:0] writeRegisterB;
  logic [WIDTH-1:0]  writeDataB;
  logic              regWriteB;
  logic              clearStart;
  logic              clearBusy;
  logic              writeConflict;

  modport master (
    output readRegister1, readRegister2,
    output writeRegister, writeData, regWrite,
    output writeRegisterB, writeDataB, regWriteB,
    output clearStart,
    input  readData1, readData2, clearBusy, writeConflict
  );

  modport slave (
    input  readRegister1, readRegister2,
    input  writeRegister, writeData, regWrite,
    input  writeRegisterB, writeDataB, regWriteB,
    input  clearStart,
    output readData1, readData2, clearBusy, writeConflict
  );
endinterface

// File: rtl/regfile_param.sv
// ---------------------------------------------------------------------------
// regfile_param
// Multi-ported register file. It has two asynchronous read ports and two
// synchronous write ports. Port A wins when both ports write the same address.
// Register 0 can optionally be hardwired to zero. A sweep-clear sequencer
// zeroes one entry per cycle.
//
// Parameters
//   WIDTH    : data bits per register
//   ADDR_W   : address bits. The array holds DEPTH = 2**ADDR_W entries.
//   ZERO_REG : when 1, register 0 always reads 0 and ignores writes.
// Ports
//   Clk   : clock. All state updates happen on the rising edge.
//   reset : synchronous, active-high. It clears the array and aborts a sweep.
//   bus   : regfile_param_if.slave
//           - read ports 1 and 2 (readRegisterN, readDataN)
//           - write port A (writeRegister, writeData, regWrite)
//           - write port B (writeRegisterB, writeDataB, regWriteB)
//           - sweep control (clearStart, clearBusy)
//           - writeConflict
// Build option
//   REGFILE_BYPASS_EN : when defined, a write that is accepted this cycle is
//                       forwarded combinationally to a read port that reads
//                       the same address.
// ---------------------------------------------------------------------------
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input logic            Clk,
  input logic            reset,
  regfile_param_if.slave bus
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] counter;
  logic              clearBusyQ;
  logic              writeConflictQ;
  logic [WIDTH-1:0]  regs [DEPTH];

  // Effective write enables. A write to the hardwired zero register does not
  // count as a write, so it can never cause a collision or a forward.
  logic weA;
  logic weB;
  logic collision;

  always_comb begin
    // NOTE: every always_comb output gets a value on every path; here they
    // are plain expressions, so no latch can be inferred.
    weA       = bus.regWrite  && !(ZERO_EN && (bus.writeRegister  == '0));
    weB       = bus.regWriteB && !(ZERO_EN && (bus.writeRegisterB == '0));
    collision = weA && weB && (bus.writeRegister == bus.writeRegisterB);
  end

  // A read returns the stored value. With bypass enabled, it returns the data
  // being written this cycle instead. Port A is checked last so that its data
  // wins on a collision. Register 0 is forced to zero after any forwarding.
  function automatic logic [WIDTH-1:0] readPort(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] data;
    data = regs[addr];
`ifdef REGFILE_BYPASS_EN
    if (state == IDLE) begin
      if (weB && (bus.writeRegisterB == addr)) data = bus.writeDataB;
      if (weA && (bus.writeRegister  == addr)) data = bus.writeData;
    end
`endif
    if (ZERO_EN && (addr == '0)) data = '0;
    return data;
  endfunction

  assign bus.readData1     = readPort(bus.readRegister1);
  assign bus.readData2     = readPort(bus.readRegister2);
  assign bus.clearBusy     = clearBusyQ;
  assign bus.writeConflict = writeConflictQ;

  // NOTE: sequential state is assigned with non-blocking (<=) only, so every
  // read inside this block sees the value from before the edge.
  always_ff @(posedge Clk) begin
    if (reset) begin
      // NOTE: the array is reset entry by entry because reset must leave every
      // register at zero. This keeps it in flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      state          <= IDLE;
      counter        <= '0;
      clearBusyQ     <= 1'b0;
      writeConflictQ <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          writeConflictQ <= collision;
          if (weB && !collision) regs[bus.writeRegisterB] <= bus.writeDataB;
          if (weA)               regs[bus.writeRegister]  <= bus.writeData;
          // Writes presented in the same cycle as clearStart still complete.
          if (bus.clearStart) begin
            state      <= CLEAR;
            counter    <= '0;
            clearBusyQ <= 1'b1;
          end
        end
        CLEAR: begin
          // Both write ports and clearStart are ignored while the sweep runs.
          writeConflictQ <= 1'b0;
          regs[counter]  <= '0;
          counter        <= counter + ADDR_W'(1);
          // The sweep ends when the counter wraps; it is back at 0 afterwards.
          if (&counter) begin
            state      <= IDLE;
            clearBusyQ <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
